seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit 7-segment display.
- Holds an N-digit hex value and steps through the digits one at a time.
- Per digit, presents the 4-bit nibble to the downstream hex-to-segment decoder, drives the one-hot digit-select lines, and supplies decimal-point and blank flags.
- Takes a frame-consistent snapshot of the value so digits never tear mid-scan.

Parameters:
N_DIGITS, 8, number of display digits (2..16); digit 0 = least significant / rightmost
PRESCALE, 10000, clk cycles each digit stays active (>= 1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  scan enable; 0 = freeze scan and turn display off
value_in  input  4*N_DIGITS  hex value to display; nibble i → digit i
dp_in  input  N_DIGITS  decimal-point request per digit
blank_lz  input  1  1 = suppress leading zeros
digit_data  output  4  nibble for current digit, to segment decoder
dp_out  output  1  decimal point for current digit
digit_blank  output  1  1 = current digit must be dark (segments gated off downstream)
digit_sel  output  N_DIGITS  active-low one-hot digit enable
scan_tick  output  1  one-cycle pulse on every digit advance

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high, sampled only on the `clk` rising edge.
- Reset values:
  - prescaler = 0, idx = 0
  - shadow value = 0, shadow dp = 0
  - digit_sel = all ones except bit0 = 0
  - digit_data = 0, dp_out = 0, digit_blank = 0, scan_tick = 0
- Reset mid-operation: the next edge returns every register to its reset value. There is no partial state.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1. Width = max(1, $clog2(PRESCALE)).
  - At terminal count it wraps to 0 and raises the advance condition.
  - PRESCALE=1 → advance every cycle.
- Advance edge:
  - idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
  - scan_tick = 1 for exactly that cycle (registered, high in the cycle after the terminal count).
- Snapshot:
  - On the advance edge where idx wraps N_DIGITS-1 → 0, shadow value and shadow dp load from value_in/dp_in.
  - Digit 0 of the new frame displays the freshly loaded data.
  - value_in changes at any other time do not affect the display.
  - The first frame after reset displays all zeros.
- All outputs are registered:
  - Loaded on the same edge idx changes, computed from the next idx and the next shadow.
  - Zero-cycle skew between digit_sel and digit_data.
- Leading-zero blank:
  - Digit i (i>0) is blanked when blank_lz=1 and shadow nibbles i..N_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - When blanked: digit_blank=1 and digit_data=0. dp_out still follows shadow dp[i].
  - When blank_lz=0: digit_blank is always 0.
- en=0:
  - Prescaler, idx and shadow hold.
  - digit_sel forced to all ones (display off) on the next edge. digit_data, dp_out and digit_blank hold. scan_tick=0.
- en 0→1: digit_sel of the held idx is restored on the next edge, and counting resumes from the held prescaler value.
- Simultaneous rst and en: rst wins.
- Simultaneous wrap and value change: the sampled value is taken.

Decomposition:
- Shared package seg_pkg:
  - DIG_ON=1'b0 and DIG_OFF=1'b1 polarity constants
  - default N_DIGITS
  - function idx_to_onehot_n (active-low one-hot)
- One sub-module: seg_tick_gen (parameter PRESCALE; ports clk, rst, en, tick). Provides the prescaler and advance pulse, and is reusable by the team's blink/debounce logic.
- Leading-zero detect is combinational inside seg_scan_ctrl.

Test Plan:
Bench configuration: N_DIGITS=4, PRESCALE=4.
1. Reset, then en=1 with value_in=16'h1234:
   - first frame digit_data=0 on every digit, digit_sel 1110→1101→1011→0111, 4 cycles each, scan_tick period 4 cycles;
   - next frame digit_data 4,3,2,1.
2. value_in=16'h0050, blank_lz=1, dp_in=4'b1000:
   - digit_blank=1 for digits 3 and 2, with dp_out=1 on digit 3;
   - digit 1 shows 5 and digit 0 shows 0, both unblanked;
   - then value 16'h0000 → only digit 0 is unblanked, showing 0.
3. Mid-frame update: change value_in 16'h1234→16'hABCD while idx=2:
   - digits 2 and 3 still show 2 and 1;
   - next frame shows D,C,B,A.
4. Deassert en while idx=1 and prescaler=2:
   - next edge digit_sel=1111, scan_tick stays 0 for 10 cycles;
   - re-enable → digit_sel=1101 on the next edge, and the advance occurs 2 cycles later.
5. Assert rst for 1 cycle at idx=3 → next edge: idx=0, digit_sel=1110, digit_data=0, scan_tick=0, and the shadow is cleared.
6. Rebuild with PRESCALE=1 → digit advances and scan_tick is high every cycle; frame length = 4 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment display blocks.
// Digit enables are active-low; the polarity lives here so every block agrees.
package seg_pkg;

    localparam logic DIG_ON       = 1'b0;
    localparam logic DIG_OFF      = 1'b1;
    localparam int   DEF_N_DIGITS = 8;
    localparam int   MAX_DIGITS   = 16;

    // Active-low one-hot over the widest supported display; callers truncate.
    function automatic logic [MAX_DIGITS-1:0] idx_to_onehot_n(input logic [3:0] idx);
        logic [MAX_DIGITS-1:0] sel;
        sel      = {MAX_DIGITS{DIG_OFF}};
        sel[idx] = DIG_ON;
        return sel;
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE-1 while enabled and flags the
// terminal count as a one-cycle advance request. Holds its count when disabled.
module seg_tick_gen #(
    parameter int PRESCALE = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] TC    = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terminal;

    always_comb begin
        terminal = (cnt_q == TC);
        cnt_d    = cnt_q;
        if (en) begin
            cnt_d = terminal ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en & terminal;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for an N-digit 7-segment display. The value is
// snapshotted at each frame wrap so a frame never mixes old and new digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS = DEF_N_DIGITS,
    parameter int PRESCALE = 10000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   value_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    blank_lz,
    output logic [3:0]              digit_data,
    output logic                    dp_out,
    output logic                    digit_blank,
    output logic [N_DIGITS-1:0]     digit_sel,
    output logic                    scan_tick
);

    localparam int                 IDX_W    = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] SEL_RST = {{(N_DIGITS-1){DIG_OFF}}, DIG_ON};

    logic                  advance;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [N_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic [3:0]            digit_data_q, digit_data_d;
    logic                  dp_out_q, dp_out_d;
    logic                  digit_blank_q, digit_blank_d;
    logic                  scan_tick_q, scan_tick_d;
    logic                  upper_zero;
    logic                  lz_blank;

    seg_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (advance)
    );

    always_comb begin
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        scan_tick_d  = 1'b0;
        if (advance) begin
            scan_tick_d = 1'b1;
            if (idx_q == LAST_IDX) begin
                idx_d        = '0;
                shadow_val_d = value_in;
                shadow_dp_d  = dp_in;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Walk down from the top digit; a digit is a leading zero only if it and
    // everything above it is zero. Digit 0 is excluded so zero still shows.
    always_comb begin
        upper_zero = 1'b1;
        lz_blank   = 1'b0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (shadow_val_d[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == idx_d) begin
                lz_blank = blank_lz & upper_zero;
            end
        end
    end

    always_comb begin
        digit_sel_d   = digit_sel_q;
        digit_data_d  = digit_data_q;
        dp_out_d      = dp_out_q;
        digit_blank_d = digit_blank_q;
        if (en) begin
            digit_sel_d   = N_DIGITS'(idx_to_onehot_n(4'(idx_d)));
            digit_data_d  = lz_blank ? 4'h0 : shadow_val_d[{idx_d, 2'b00} +: 4];
            dp_out_d      = shadow_dp_d[idx_d];
            digit_blank_d = lz_blank;
        end else begin
            digit_sel_d = {N_DIGITS{DIG_OFF}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q         <= '0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            digit_sel_q   <= SEL_RST;
            digit_data_q  <= '0;
            dp_out_q      <= 1'b0;
            digit_blank_q <= 1'b0;
            scan_tick_q   <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            digit_sel_q   <= digit_sel_d;
            digit_data_q  <= digit_data_d;
            dp_out_q      <= dp_out_d;
            digit_blank_q <= digit_blank_d;
            scan_tick_q   <= scan_tick_d;
        end
    end

    assign digit_sel   = digit_sel_q;
    assign digit_data  = digit_data_q;
    assign dp_out      = dp_out_q;
    assign digit_blank = digit_blank_q;
    assign scan_tick   = scan_tick_q;

endmodule
